multicycle_control_fsm: RTL

- Main control state machine for the multi-cycle RISC_PROC core.
- Sequences fetch, decode, execute, memory and writeback for each instruction from the 4-bit opcode.
- Drives the 3-bit aluOp consumed by ALU_Control, plus the mux selects, register-file, PC and memory strobes.
- Sits between the instruction register and the datapath. Handles the memory ready handshake and watchdogs it.

---
 rtl/multicycle_control_fsm_pkg.sv | 35 +++
 rtl/multicycle_control_fsm_if.sv | 32 +++
 rtl/multicycle_control_fsm_mem_wait_watchdog.sv | 30 +++
 rtl/multicycle_control_fsm.sv | 110 +++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: opcode, aluOp, mux-select and 4-bit state encodings plus decode helpers for the control FSM
package multicycle_control_fsm_pkg;
  localparam logic [3:0] OP_RTYPE = 4'd0, OP_ADDI = 4'd1, OP_SHIFT = 4'd2, OP_LW = 4'd3,
                         OP_SW = 4'd4, OP_BEQ = 4'd5, OP_JMP = 4'd6, OP_LUI = 4'd7, OP_HALT = 4'd15;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_FUNC = 3'd2, ALU_SHIFT = 3'd3, ALU_LUI = 3'd4;
  localparam logic [1:0] SRCB_REGB = 2'b00, SRCB_ONE = 2'b01, SRCB_IMM = 2'b10, SRCB_OFF = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_WB_ALU = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_e;
  function automatic state_e decode_next(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_SHIFT, OP_LUI: return S_EXEC;
      OP_LW, OP_SW:                         return S_ADDR;
      OP_BEQ:                               return S_BRANCH;
      OP_JMP:                               return S_JUMP;
      OP_HALT:                              return S_HALT;
      default:                              return S_FETCH;
    endcase
  endfunction
  function automatic logic is_mem_state(input state_e s);
    return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control bus; master (FSM) takes opcode/zero/memReady and drives memory, mux, PC, regfile strobes and status
interface multicycle_control_fsm_if;
  logic [3:0] opcode;
  logic       zero;
  logic       memReady;
  logic       memReq;
  logic       memWrite;
  logic       iOrD;
  logic       irWrite;
  logic       pcWrite;
  logic       pcWriteCond;
  logic [1:0] pcSource;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluOp;
  logic       regWrite;
  logic       regDst;
  logic       memToReg;
  logic       illegalOp;
  logic       busError;
  logic       halted;
  modport master (
    input  opcode, zero, memReady,
    output memReq, memWrite, iOrD, irWrite, pcWrite, pcWriteCond, pcSource,
           aluSrcA, aluSrcB, aluOp, regWrite, regDst, memToReg, illegalOp, busError, halted
  );
  modport slave (
    output opcode, zero, memReady,
    input  memReq, memWrite, iOrD, irWrite, pcWrite, pcWriteCond, pcSource,
           aluSrcA, aluSrcB, aluOp, regWrite, regDst, memToReg, illegalOp, busError, halted
  );
endinterface

// File: rtl/multicycle_control_fsm_mem_wait_watchdog.sv
// multicycle_control_fsm_mem_wait_watchdog: counts unanswered memReq cycles; timeout_o on the WAIT_LIMIT-th, sticky bus_error_o; ports clk, rst_n, req_i, ready_i, start_i
module multicycle_control_fsm_mem_wait_watchdog #(
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ready_i,
  input  logic start_i,
  output logic timeout_o,
  output logic bus_error_o
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic bus_error_q, bus_error_d;
  assign timeout_o   = req_i && !ready_i && cnt_q == WAIT_W'(WAIT_LIMIT - 1);
  assign bus_error_o = bus_error_q;
  always_comb begin
    cnt_d       = (start_i || (req_i && ready_i)) ? '0 : req_i ? cnt_q + WAIT_W'(1) : cnt_q;
    bus_error_d = bus_error_q || timeout_o;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: fetch/decode/execute/mem/writeback sequencer; ports clk, rst_n (async low), bus (opcode/zero/memReady in, datapath strobes and status out)
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_W     = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_fsm_if.master  bus
);
  state_e state_q, state_d;
  logic mem_req, start, timeout, bus_error, rtype;
  assign mem_req      = is_mem_state(state_q);
  assign start        = is_mem_state(state_d) && state_d != state_q;
  assign rtype        = bus.opcode == OP_RTYPE;
  assign bus.memReq   = mem_req;
  assign bus.busError = bus_error;
  assign bus.halted   = state_q == S_HALT;
  multicycle_control_fsm_mem_wait_watchdog #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .WAIT_W    (WAIT_W)
  ) u_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (mem_req),
    .ready_i    (bus.memReady),
    .start_i    (start),
    .timeout_o  (timeout),
    .bus_error_o(bus_error)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d         = state_q;
    bus.memWrite    = 1'b0;
    bus.iOrD        = 1'b0;
    bus.irWrite     = 1'b0;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.pcSource    = PCSRC_ALU;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = SRCB_REGB;
    bus.aluOp       = ALU_ADD;
    bus.regWrite    = 1'b0;
    bus.regDst      = 1'b0;
    bus.memToReg    = 1'b0;
    bus.illegalOp   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.aluSrcB = SRCB_ONE;
        bus.irWrite = bus.memReady;
        bus.pcWrite = bus.memReady;
        state_d     = bus.memReady ? S_DECODE : timeout ? S_HALT : S_FETCH;
      end
      S_DECODE: begin
        bus.aluSrcB   = SRCB_OFF;
        state_d       = decode_next(bus.opcode);
        bus.illegalOp = state_d == S_FETCH;
      end
      S_EXEC: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = (rtype || bus.opcode == OP_SHIFT) ? SRCB_REGB : SRCB_IMM;
        bus.aluOp   = rtype ? ALU_FUNC : bus.opcode == OP_SHIFT ? ALU_SHIFT :
                      bus.opcode == OP_LUI ? ALU_LUI : ALU_ADD;
        state_d     = S_WB_ALU;
      end
      S_WB_ALU: begin
        bus.regWrite = 1'b1;
        bus.regDst   = rtype;
        state_d      = S_FETCH;
      end
      S_ADDR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
        state_d     = bus.opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.iOrD = 1'b1;
        state_d  = bus.memReady ? S_WB_MEM : timeout ? S_HALT : S_MEM_RD;
      end
      S_MEM_WR: begin
        bus.iOrD     = 1'b1;
        bus.memWrite = 1'b1;
        state_d      = bus.memReady ? S_FETCH : timeout ? S_HALT : S_MEM_WR;
      end
      S_WB_MEM: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.aluOp       = ALU_SUB;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = PCSRC_ALUOUT;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        bus.pcWrite  = 1'b1;
        bus.pcSource = PCSRC_JUMP;
        state_d      = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end
endmodule
